// File: rtl/grid_update_rx.sv
// grid_update_rx
// Receives 16-bit cell-update frames over a 3-wire serial link (SCK/MOSI/CS_N),
// maintains the maze grid colour memory and serves registered colour reads
// to the grid-drawing logic.
module grid_update_rx #(
    parameter int          GRID_COLS   = 2,
    parameter int          GRID_ROWS   = 2,
    parameter logic [7:0]  RESET_COLOR = 8'b000_111_00
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       SCK,
    input  logic       MOSI,
    input  logic       CS_N,
    input  logic [1:0] RD_X,
    input  logic [1:0] RD_Y,
    output logic [7:0] RD_COLOR,
    output logic       PKT_VALID,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int         CELLS     = GRID_COLS * GRID_ROWS;
    localparam logic [3:0] LAST_CELL = 4'(CELLS - 1);
    localparam logic [3:0] COLS_4    = 4'(GRID_COLS);
    localparam logic [2:0] COLS_3    = 3'(GRID_COLS);
    localparam logic [2:0] ROWS_3    = 3'(GRID_ROWS);
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_CLEAR = 4'h2;
    localparam logic [4:0] FRAME_LEN = 5'd16;
    localparam logic [4:0] CNT_SAT   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_CLEAR
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronisers and edge detection
    // ---------------------------------------------------------------
    logic [1:0] sck_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic [1:0] cs_sync_reg;
    logic       sck_prev_reg;
    logic       cs_prev_reg;
    logic [1:0] settle_reg;

    // Two-flop synchronisers, edge registers and a post-reset settle counter.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sck_sync_reg  <= 2'b00;
            mosi_sync_reg <= 2'b00;
            cs_sync_reg   <= 2'b11;
            sck_prev_reg  <= 1'b0;
            cs_prev_reg   <= 1'b1;
            settle_reg    <= 2'd0;
        end else begin
            sck_sync_reg  <= {sck_sync_reg[0], SCK};
            mosi_sync_reg <= {mosi_sync_reg[0], MOSI};
            cs_sync_reg   <= {cs_sync_reg[0], CS_N};
            sck_prev_reg  <= sck_sync_reg[1];
            cs_prev_reg   <= cs_sync_reg[1];
            if (settle_reg != 2'd3) begin
                settle_reg <= settle_reg + 2'd1;
            end
        end
    end

    // CS_N edges only count once the real pin level has flushed the reset
    // value out of the chain; otherwise a reset in mid-frame (CS_N held low)
    // would look like a fresh falling edge and start a bogus frame.
    logic cs_settled;
    logic cs_fall;
    logic cs_rise;
    logic sck_rise;
    logic mosi_bit;

    assign cs_settled = (settle_reg == 2'd3);
    assign cs_fall    = cs_settled &  cs_prev_reg & ~cs_sync_reg[1];
    assign cs_rise    = cs_settled & ~cs_prev_reg &  cs_sync_reg[1];
    assign sck_rise   = sck_sync_reg[1] & ~sck_prev_reg;
    assign mosi_bit   = mosi_sync_reg[1];

    // ---------------------------------------------------------------
    // Frame receiver FSM
    // ---------------------------------------------------------------
    state_t      state_reg,   state_next;
    logic [15:0] shift_reg,   shift_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [3:0]  clr_idx_reg, clr_idx_next;
    logic        orphan_reg,  orphan_next;   // frame began during a clear

    logic [1:0]  f_x;
    logic [1:0]  f_y;
    logic [3:0]  f_cmd;
    logic [7:0]  f_color;
    logic        f_in_range;
    logic [3:0]  f_idx;

    assign f_x        = shift_reg[15:14];
    assign f_y        = shift_reg[13:12];
    assign f_cmd      = shift_reg[11:8];
    assign f_color    = shift_reg[7:0];
    assign f_in_range = ({1'b0, f_x} < COLS_3) && ({1'b0, f_y} < ROWS_3);
    assign f_idx      = ({2'b00, f_y} * COLS_4) + {2'b00, f_x};

    logic       wr_en;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;

    // FSM state and datapath registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= 16'h0000;
            bit_cnt_reg <= 5'd0;
            clr_idx_reg <= 4'd0;
            orphan_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            clr_idx_reg <= clr_idx_next;
            orphan_reg  <= orphan_next;
        end
    end

    // Next-state, frame check, memory write request and status pulses.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        clr_idx_next = clr_idx_reg;
        orphan_next  = orphan_reg;
        wr_en        = 1'b0;
        wr_idx       = f_idx;
        wr_data      = f_color;
        PKT_VALID    = 1'b0;
        FRAME_ERR    = 1'b0;
        BUSY         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next   = ST_SHIFT;
                    shift_next   = 16'h0000;
                    bit_cnt_next = 5'd0;
                    orphan_next  = 1'b0;
                end else if (cs_rise && orphan_reg) begin
                    // End of a frame whose start was swallowed by a clear.
                    FRAME_ERR   = 1'b1;
                    orphan_next = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    shift_next = {shift_reg[14:0], mosi_bit};
                    if (bit_cnt_reg != CNT_SAT) begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
                if (cs_rise) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
                if (bit_cnt_reg != FRAME_LEN) begin
                    FRAME_ERR = 1'b1;
                end else if (f_cmd == CMD_WRITE) begin
                    if (f_in_range) begin
                        wr_en     = 1'b1;
                        PKT_VALID = 1'b1;
                    end else begin
                        FRAME_ERR = 1'b1;
                    end
                end else if (f_cmd == CMD_CLEAR) begin
                    PKT_VALID    = 1'b1;
                    state_next   = ST_CLEAR;
                    clr_idx_next = 4'd0;
                end else begin
                    FRAME_ERR = 1'b1;
                end
            end
            ST_CLEAR: begin
                BUSY    = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = clr_idx_reg;
                wr_data = RESET_COLOR;
                if (cs_fall) begin
                    orphan_next = 1'b1;
                end else if (cs_rise) begin
                    orphan_next = 1'b0;
                end
                if (clr_idx_reg == LAST_CELL) begin
                    state_next = ST_IDLE;
                end else begin
                    clr_idx_next = clr_idx_reg + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Grid colour memory, row-major: index = y * GRID_COLS + x
    // ---------------------------------------------------------------
    logic [7:0] cell_rd [CELLS];

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            logic [7:0] cell_reg;

            // One colour cell, loaded with RESET_COLOR on reset.
            always_ff @(posedge CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    cell_reg <= RESET_COLOR;
                end else if (wr_en && (wr_idx == 4'(gi))) begin
                    cell_reg <= wr_data;
                end
            end

            assign cell_rd[gi] = cell_reg;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Read port
    // ---------------------------------------------------------------
    logic       rd_in_range;
    logic [3:0] rd_idx;
    logic [7:0] rd_data;

    assign rd_in_range = ({1'b0, RD_X} < COLS_3) && ({1'b0, RD_Y} < ROWS_3);
    assign rd_idx      = ({2'b00, RD_Y} * COLS_4) + {2'b00, RD_X};

    // Cell select; indices outside the grid read as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < CELLS; i++) begin
            if (rd_in_range && (rd_idx == 4'(i))) begin
                rd_data = cell_rd[i];
            end
        end
    end

    // Registered read data; a same-cycle write is seen on the following read.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_COLOR <= 8'h00;
        end else begin
            RD_COLOR <= rd_data;
        end
    end

endmodule
